// File: rtl/des_perm_pipe.sv
// rtl/des_perm_pipe.sv - pipelined DES IP / IP^-1 permutation over LANES 64-bit blocks
// Optional per-lane parity carry/check enabled by defining DES_PERM_PARITY_EN.
module des_perm_pipe #(
   parameter int LANES       = 1,
   parameter int PIPE_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_mode,
   input  logic [64*LANES-1:0] in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [64*LANES-1:0] out_data,
   output logic                out_mode,
   output logic                out_par_err
);
   localparam int DW = 64*LANES;
   localparam int NS = PIPE_STAGES;

   if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
      $error("des_perm_pipe: PIPE_STAGES must be in 1..4");
   end

   // Source bit of FP output bit 8r+c; IP scatters through the same index.
   function automatic logic [5:0] fp_src(input int r, input int c);
      return 6'((39 - r) - 32*(c % 2) + 8*(c / 2));
   endfunction

   function automatic logic [63:0] fp64(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            y[6'(8*r + c)] = x[fp_src(r, c)];
         end
      end
      return y;
   endfunction

   function automatic logic [63:0] ip64(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            y[fp_src(r, c)] = x[6'(8*r + c)];
         end
      end
      return y;
   endfunction

   logic [DW-1:0]          perm_data;
   logic [NS-1:0]          sv;
   logic [NS-1:0]          sm;
   logic [NS-1:0][DW-1:0]  sd;
   logic [NS-1:0]          load;
   logic                   tail_full;
   logic                   accept;
   logic [DW-1:0]          last_data;

   always_comb begin
      perm_data = '0;
      for (int k = 0; k < LANES; k++) begin
         perm_data[64*k +: 64] = in_mode ? fp64(in_data[64*k +: 64])
                                         : ip64(in_data[64*k +: 64]);
      end
   end

   // A stage may load unless it and every stage after it are full with the output stalled.
   always_comb begin
      load      = '0;
      tail_full = 1'b1;
      for (int k = NS-1; k >= 0; k--) begin
         tail_full = tail_full & sv[k];
         load[k]   = ~tail_full | out_ready;
      end
   end

   assign in_ready = load[0] & ~flush;
   assign accept   = in_valid & in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sv <= '0;
         sm <= '0;
         sd <= '0;
      end else begin
         if (load[0]) begin
            sv[0] <= accept;
            if (accept) begin
               sm[0] <= in_mode;
               sd[0] <= perm_data;
            end
         end
         for (int k = 1; k < NS; k++) begin
            if (load[k]) begin
               sv[k] <= sv[k-1];
               if (sv[k-1]) begin
                  sm[k] <= sm[k-1];
                  sd[k] <= sd[k-1];
               end
            end
         end
         if (flush) begin
            sv <= '0;
         end
      end
   end

   assign last_data = sd[NS-1];
   assign out_valid = sv[NS-1];
   assign out_mode  = sm[NS-1];
   assign out_data  = last_data;

`ifdef DES_PERM_PARITY_EN
   logic [NS-1:0][LANES-1:0] sp;
   logic [LANES-1:0]         in_par;
   logic [LANES-1:0]         out_par;
   logic                     par_err;
   logic                     par_sticky;

   always_comb begin
      in_par  = '0;
      out_par = '0;
      for (int k = 0; k < LANES; k++) begin
         in_par[k]  = ^in_data[64*k +: 64];
         out_par[k] = ^last_data[64*k +: 64];
      end
   end

   assign par_err     = sv[NS-1] & (|(out_par ^ sp[NS-1]));
   assign out_par_err = par_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp         <= '0;
         par_sticky <= 1'b0;
      end else begin
         if (load[0] && accept) begin
            sp[0] <= in_par;
         end
         for (int k = 1; k < NS; k++) begin
            if (load[k] && sv[k-1]) begin
               sp[k] <= sp[k-1];
            end
         end
         par_sticky <= par_sticky | par_err;
      end
   end
`else
   assign out_par_err = 1'b0;
`endif

endmodule

// File: doc/des_perm_pipe.md
Name: des_perm_pipe

Overview:
- Parametrised, pipelined successor to the fixed 64-bit DES final-permutation block.
- Applies either the DES initial permutation (IP) or its inverse (IP^-1 / FP) to LANES independent 64-bit blocks per beat.
- Per-beat mode select; valid/ready handshake with full backpressure; PIPE_STAGES register stages.
- Sits at the entry (IP) and exit (FP) of the pipelined DES datapath. One instance serves either end or a shared encrypt/decrypt wrapper.

Parameters:
- LANES, 1, number of 64-bit blocks carried per beat; data width = 64*LANES.
- PIPE_STAGES, 2, number of register stages, legal 1..4; elaboration error outside range.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline clear.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_mode  in  1  0 = IP, 1 = IP^-1 (FP); sampled with the beat.
- in_data  in  64*LANES  lane k = bits [64k+63:64k].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  64*LANES  permuted lanes.
- out_mode  out  1  mode that travelled with the beat.
- out_par_err  out  1  parity-check error; see Optional Feature.

Behaviour:
- Bit convention is LSB-indexed (bit 0 = in[0]).
- FP mapping per lane:
  - out[8r+c] = in[(39-r) - 32*(c odd) + 8*(c>>1)], for r = 0..7 and c = 0..7.
  - Examples: out[0]=in[39], out[1]=in[7], out[57]=in[0], out[63]=in[24].
- IP is the exact inverse: IP(FP(x)) = x, for example out[39]=in[0].
- The permutation is combinational ahead of stage 1. Stages 2..PIPE_STAGES are pure delay registers. Each stage holds {valid, mode, data}.
- Accept: a beat is transferred when in_valid & in_ready.
- Stage k advance rule: stage k loads from stage k-1 when stage k is empty or stage k+1 (or the output when k is last) takes its beat.
  - Bubbles collapse.
  - in_ready = ~v1 | advance1. It is combinational from out_ready through the chain; there is no skid buffer.
- Output: out_valid = v_last. out_data and out_mode come from the last stage. A beat leaves when out_valid & out_ready.
- Out_data holds stable while out_valid & ~out_ready. No beat is ever dropped or duplicated.
- Latency is PIPE_STAGES cycles from accept to out_valid with out_ready held 1. Throughput is 1 beat/cycle.
- Stalls: with out_ready=0 the pipe fills to PIPE_STAGES beats, then in_ready=0.
- Simultaneous pop at the last stage and push at stage 1 in the same cycle are both honoured (full pipe stays full).
- flush=1: on the next edge all valid bits clear. An input beat offered that cycle is discarded and in_ready is forced 0 during flush.
- Flush has priority over advance.
- Reset (rst_n=0, asynchronous): all valid bits, mode and data registers are 0. Outputs are then out_valid=0, out_data=0, out_mode=0, out_par_err=0, and in_ready=1 after release.
- Reset mid-stream discards all in-flight beats.
- Lanes are independent; mode applies to all lanes of the beat.

Optional Feature:
- Macro: DES_PERM_PARITY_EN.
- Defined:
  - Per lane, the XOR-reduction of the input block is captured at accept and carried alongside the data.
  - At the last stage it is compared with the XOR-reduction of out_data for that lane. A permutation preserves popcount, so any mismatch indicates a register/datapath fault.
  - out_par_err = out_valid & (any lane mismatch), aligned with the beat.
  - A sticky internal flag also sets on any error and is cleared only by rst_n.
- Not defined: no parity storage; out_par_err tied 0.

Test Plan:
- Single beat, LANES=1, PIPE_STAGES=2, mode=1, in_data=64'h0000_0000_0000_0001 → out_data=64'h0200_0000_0000_0000, out_valid 2 cycles after accept.
- Same input with mode=0 → out_data=64'h0000_0080_0000_0000. Chaining FP then IP on 64'h0123_4567_89AB_CDEF returns 64'h0123_4567_89AB_CDEF. 64'hFFFF_FFFF_FFFF_FFFF maps to itself in both modes.
- Streaming 16 random beats with out_ready random 50% and in_valid random 70%, checked against a reference model → order preserved, no drop/duplicate, out_data stable while stalled.
- out_ready=0 for 6 cycles, continuous in_valid → exactly PIPE_STAGES beats accepted, then in_ready=0. Releasing out_ready drains at 1 beat/cycle.
- flush asserted with 2 beats in flight → next cycle out_valid=0, and those beats never appear. Async rst_n pulse mid-stream → outputs 0 immediately, in_ready=1 after release.
- LANES=2 with mixed lane data; with DES_PERM_PARITY_EN, force one last-stage data bit → out_par_err=1 only on that beat. Without the macro, out_par_err stays 0.
